// File: rtl/nios_system_pio_gen2.sv
// Avalon-MM parallel I/O port: data/direction/irqmask/edgecapture registers,
// set/clear aliases for the output latch, synchronised inputs with edge capture.
module nios_system_pio_gen2 #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    logic [WIDTH-1:0] data_out, data_next;
    logic [WIDTH-1:0] direction, irqmask, edgecapture, ec_next;
    logic [WIDTH-1:0] sync_meta, sync, prev;
    logic [WIDTH-1:0] edges, ec_clr, wdata;
    logic [1:0]       arm;
    logic             wr, armed;
    logic             unused_wdata;

    assign wr           = chipselect && !write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign armed        = (arm == 2'd3);

    // Edge selection; suppressed until the synchroniser and history have filled
    always_comb begin
        edges = '0;
        if (EDGE_TYPE == 0) begin
            edges = sync & ~prev;
        end else if (EDGE_TYPE == 1) begin
            edges = ~sync & prev;
        end else begin
            edges = sync ^ prev;
        end
        if (!armed) begin
            edges = '0;
        end
    end

    // Write-1-clear is applied before the set so a coincident edge wins
    always_comb begin
        ec_clr = '0;
        if (wr && address == ADDR_EDGE) begin
            ec_clr = wdata;
        end
        ec_next = (edgecapture & ~ec_clr) | edges;
    end

    always_comb begin
        data_next = data_out;
        if (wr) begin
            case (address)
                ADDR_DATA: data_next = wdata;
                ADDR_SET:  data_next = data_out | wdata;
                ADDR_CLR:  data_next = data_out & ~wdata;
                default:   data_next = data_out;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out    <= WIDTH'(RESET_VALUE);
            direction   <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            sync_meta   <= '0;
            sync        <= '0;
            prev        <= '0;
            arm         <= 2'd0;
        end else begin
            data_out    <= data_next;
            edgecapture <= ec_next;
            sync_meta   <= in_port;
            sync        <= sync_meta;
            prev        <= sync;
            if (!armed) begin
                arm <= arm + 2'd1;
            end
            if (wr && address == ADDR_DIR) begin
                direction <= wdata;
            end
            if (wr && address == ADDR_MASK) begin
                irqmask <= wdata;
            end
        end
    end

    // Zero-latency read mux; unused addresses and the set/clear aliases read 0
    always_comb begin
        readdata = 32'h0;
        case (address)
            ADDR_DATA: readdata = 32'((direction & data_out) | (~direction & sync));
            ADDR_DIR:  readdata = 32'(direction);
            ADDR_MASK: readdata = 32'(irqmask);
            ADDR_EDGE: readdata = 32'(edgecapture);
            default:   readdata = 32'h0;
        endcase
    end

    assign out_port = data_out;
    assign oe       = direction;
    assign irq      = |(edgecapture & irqmask);

endmodule

// File: doc/nios_system_pio_gen2.md
NIOS_SYSTEM_PIO_GEN2 -- requirements
Module: nios_system_pio_gen2

Interface
REQ-001 Parameter WIDTH, default 8, meaning port width in bits; the legal range SHALL be 1..32.
REQ-002 Parameter RESET_VALUE, default 0, meaning the reset value of the output data register (WIDTH bits).
REQ-003 Parameter EDGE_TYPE, default 0, meaning the capture edge: 0 rising, 1 falling, 2 any.
REQ-004 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-005 reset_n  input  1  reset; synchronous and active-low.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data; bits [31:WIDTH] SHALL be ignored.
REQ-010 readdata  output  32  read data; bits [31:WIDTH] SHALL read 0.
REQ-011 in_port  input  WIDTH  asynchronous pin inputs.
REQ-012 out_port  output  WIDTH  driven pin values.
REQ-013 oe  output  WIDTH  per-bit output enable; it SHALL equal the direction register.
REQ-014 irq  output  1  active-high level interrupt.

Function
REQ-015 Register map: 0 data; 1 direction (1 = output); 2 irqmask; 3 edgecapture; 4 outset; 5 outclear; 6 and 7 reserved.
REQ-016 A write SHALL occur when chipselect=1 and write_n=0, taking effect on that clock edge.
REQ-017 readdata SHALL be combinational from address and register state with read latency 0; reserved addresses, outset and outclear SHALL read 0.
REQ-018 in_port SHALL pass through a 2-flop synchroniser (sync) followed by a history register (prev).
REQ-019 Reading data SHALL return, per bit, data_out where direction=1, else sync.
REQ-020 A write to data SHALL load data_out; a write to outset SHALL OR writedata into data_out; a write to outclear SHALL AND ~writedata into data_out.
REQ-021 out_port SHALL equal data_out at all times, regardless of direction.
REQ-022 Edge detection: rising = sync & ~prev; falling = ~sync & prev; any = sync ^ prev; the result SHALL be selected by EDGE_TYPE.
REQ-023 An edgecapture bit SHALL set on a detected edge and hold until cleared; a write to edgecapture SHALL clear each bit written as 1.
REQ-024 If an edge and a write-1-clear hit the same bit in the same cycle, set SHALL win.
REQ-025 Detection SHALL apply to all bits; edges on output-direction bits SHALL also be captured.
REQ-026 A 2-bit arm counter SHALL count 0..3 after reset and saturate; edge detection SHALL be suppressed until it reaches 3, so that synchroniser fill cannot cause false captures.
REQ-027 irq SHALL be |(edgecapture & irqmask), combinational from registers, with no added latency beyond the capture cycle.
REQ-028 Latency from an in_port transition to an edgecapture bit set SHALL be 3 clocks (2 sync, 1 capture), and irq SHALL assert in the same cycle as the set.

Reset
REQ-029 On a clk edge with reset_n=0: data_out=RESET_VALUE, direction=0, irqmask=0, edgecapture=0, sync=0, prev=0, arm counter=0.
REQ-030 Reset asserted mid-operation SHALL override any simultaneous write, and irq SHALL be 0 in the cycle after reset.
REQ-031 After reset: out_port=RESET_VALUE, oe=0, irq=0, and readdata SHALL reflect the reset state.

Verification
REQ-032 WIDTH=8, RESET_VALUE=0xA5: reset -> out_port=0xA5, oe=0x00, irq=0; read direction -> 0.
REQ-033 Write data=0x0F, outset=0x30, outclear=0x03 -> out_port sequence 0x0F, 0x3F, 0x3C; write 0xFFFFFF00 to data -> out_port=0x00.
REQ-034 EDGE_TYPE=0, irqmask=0x01, in_port[0] 0->1 -> edgecapture=0x01 and irq=1 exactly 3 clocks later; write edgecapture=0x01 -> irq=0 next cycle.
REQ-035 Rising edge on bit 2 arriving in the same cycle as a write-clear of edgecapture 0x04 -> bit 2 remains 1.
REQ-036 in_port=0xFF held through reset release -> edgecapture stays 0x00; direction=0xF0, data=0x50, in_port=0x0A -> read data = 0x5A.
